// File: rtl/freq_clk_div_multi.sv
// freq_clk_div_multi
// Multi-channel divided-clock / clock-enable generator with per-channel
// reset sequencing. Every channel divides the system clock by a runtime
// programmable integer (odd values included). New settings are held as
// pending and take effect only on a period boundary, so a running channel
// never emits a runt pulse.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   cfg_we    single-cycle configuration write strobe
//   cfg_ch    target channel of the write (writes to channels >= NUM_CH ignored)
//   cfg_div   requested divisor (values below 2 are stored as 2)
//   cfg_en    requested channel enable
//   cfg_rst   re-arm the channel reset sequence when the write is applied
//   ch_clk    registered divided clock per channel (data-path use only)
//   ch_tick   one-cycle pulse in the cycle ch_clk rises
//   ch_rst    per-channel synchronous reset, active-high
//   ch_rst_   inverse of ch_rst
//   cfg_pend  channel holds an accepted write that is not yet applied
module freq_clk_div_multi #(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 16,
  parameter int RST_CYCLES = 4,
  parameter int DEF_DIV    = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              cfg_rst,
  output logic [NUM_CH-1:0] ch_clk,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] ch_rst,
  output logic [NUM_CH-1:0] ch_rst_,
  output logic [NUM_CH-1:0] cfg_pend
);

  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_DEF  = DIV_W'(DEF_DIV);
  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);

  // Divisors below 2 cannot produce a clock, so they are raised to 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    logic [DIV_W-1:0] r;
    if (d < DIV_MIN) begin
      r = DIV_MIN;
    end else begin
      r = d;
    end
    return r;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_r, div_act_r, pend_div_r;
    logic             en_act_r, pend_r, pend_en_r, pend_rst_r;
    logic             clk_r, tick_r, rst_r, rst_n_r;
    logic [7:0]       rst_cnt_r;

    logic             wr_s, wrap_s, apply_s, arm_s;
    logic [DIV_W-1:0] half_s, cnt_nxt_s, div_nxt_s;
    logic             en_nxt_s, pend_nxt_s, rst_nxt_s;
    logic [7:0]       rst_cnt_nxt_s;

    // Next-state logic: counter, apply of pending settings, reset sequencer.
    always_comb begin
      wr_s          = cfg_we && (cfg_ch == CH_W'(g));
      wrap_s        = en_act_r && (cnt_r == (div_act_r - DIV_ONE));
      // Idle channels take settings at once; running ones only at the end of
      // the wrap cycle, so the current period always finishes on the old divisor.
      apply_s       = pend_r && (!en_act_r || wrap_s);
      arm_s         = apply_s && (pend_rst_r || (pend_en_r && !en_act_r));
      // High phase is ceil(D/2) cycles.
      half_s        = (div_act_r >> 1) + {{(DIV_W-1){1'b0}}, div_act_r[0]};
      cnt_nxt_s     = cnt_r;
      div_nxt_s     = div_act_r;
      en_nxt_s      = en_act_r;
      pend_nxt_s    = pend_r;
      rst_nxt_s     = rst_r;
      rst_cnt_nxt_s = rst_cnt_r;

      if (apply_s) begin
        cnt_nxt_s = DIV_ZERO;
        div_nxt_s = pend_div_r;
        en_nxt_s  = pend_en_r;
      end else if (wrap_s) begin
        cnt_nxt_s = DIV_ZERO;
      end else if (en_act_r) begin
        cnt_nxt_s = cnt_r + DIV_ONE;
      end else begin
        cnt_nxt_s = DIV_ZERO;
      end

      // A write in the same cycle as an apply becomes the next pending value.
      if (wr_s) begin
        pend_nxt_s = 1'b1;
      end else if (apply_s) begin
        pend_nxt_s = 1'b0;
      end else begin
        pend_nxt_s = pend_r;
      end

      // Re-arm wins over a tick landing in the same cycle.
      if (arm_s) begin
        rst_nxt_s     = 1'b1;
        rst_cnt_nxt_s = 8'd0;
      end else if (rst_r && tick_r) begin
        rst_cnt_nxt_s = rst_cnt_r + 8'd1;
        if (rst_cnt_r == RST_LAST) begin
          rst_nxt_s = 1'b0;
        end else begin
          rst_nxt_s = 1'b1;
        end
      end else begin
        rst_nxt_s     = rst_r;
        rst_cnt_nxt_s = rst_cnt_r;
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r      <= DIV_ZERO;
        div_act_r  <= DIV_DEF;
        en_act_r   <= 1'b0;
        pend_r     <= 1'b0;
        pend_div_r <= DIV_DEF;
        pend_en_r  <= 1'b0;
        pend_rst_r <= 1'b0;
        clk_r      <= 1'b0;
        tick_r     <= 1'b0;
        rst_r      <= 1'b1;
        rst_n_r    <= 1'b0;
        rst_cnt_r  <= 8'd0;
      end else begin
        cnt_r     <= cnt_nxt_s;
        div_act_r <= div_nxt_s;
        en_act_r  <= en_nxt_s;
        pend_r    <= pend_nxt_s;
        if (wr_s) begin
          pend_div_r <= clamp_div(cfg_div);
          pend_en_r  <= cfg_en;
          pend_rst_r <= cfg_rst;
        end else begin
          pend_div_r <= pend_div_r;
          pend_en_r  <= pend_en_r;
          pend_rst_r <= pend_rst_r;
        end
        clk_r     <= en_act_r && (cnt_r < half_s);
        tick_r    <= en_act_r && (cnt_r == DIV_ZERO);
        rst_r     <= rst_nxt_s;
        rst_n_r   <= !rst_nxt_s;
        rst_cnt_r <= rst_cnt_nxt_s;
      end
    end

    assign ch_clk[g]   = clk_r;
    assign ch_tick[g]  = tick_r;
    assign ch_rst[g]   = rst_r;
    assign ch_rst_[g]  = rst_n_r;
    assign cfg_pend[g] = pend_r;
  end

endmodule

// File: tb/tb_freq_clk_div_multi.sv
// Self-checking bench for freq_clk_div_multi. The reference model describes
// each channel by its divisor, enable and the edge at which its current
// setting was applied; outputs follow from the phase (t - start) mod D.
module tb_freq_clk_div_multi;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int RSTC   = 4;
  localparam int DEFD   = 2;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic cfg_en = 1'b0;
  logic cfg_rst = 1'b0;
  logic [NUM_CH-1:0] ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend;

  freq_clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(RSTC), .DEF_DIV(DEFD)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .cfg_rst(cfg_rst), .ch_clk(ch_clk), .ch_tick(ch_tick),
    .ch_rst(ch_rst), .ch_rst_(ch_rst_), .cfg_pend(cfg_pend));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int e      = 0;

  // Model state per channel.
  bit m_en[NUM_CH];
  int m_div[NUM_CH];
  int m_a[NUM_CH];
  bit m_pv[NUM_CH];
  int m_pdiv[NUM_CH];
  bit m_pen[NUM_CH];
  bit m_prs[NUM_CH];
  bit m_rst[NUM_CH];
  int m_ticks[NUM_CH];
  logic [NUM_CH-1:0] exp_clk, exp_tick, exp_rst, exp_pend;
  localparam logic [NUM_CH-1:0] ALL1 = {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] ALL0 = {NUM_CH{1'b0}};

  function automatic bit clk_at(int c, int t);
    if (!m_en[c] || t < m_a[c] + 1) return 1'b0;
    return ((t - m_a[c] - 1) % m_div[c]) < ((m_div[c] + 1) / 2);
  endfunction

  function automatic bit tick_at(int c, int t);
    if (!m_en[c] || t < m_a[c] + 1) return 1'b0;
    return ((t - m_a[c] - 1) % m_div[c]) == 0;
  endfunction

  function automatic int cnt_now(int c);
    return (e - m_a[c]) % m_div[c];
  endfunction

  task automatic model_edge(input bit we, input int ch, input int div, input bit en, input bit rs, input bit r);
    e++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r) begin
        m_en[c] = 0; m_div[c] = DEFD; m_a[c] = e; m_pv[c] = 0; m_rst[c] = 1; m_ticks[c] = 0;
      end else begin
        if (m_rst[c] && tick_at(c, e - 1)) begin
          m_ticks[c]++;
          if (m_ticks[c] == RSTC) m_rst[c] = 0;
        end
        if (m_pv[c] && (!m_en[c] || ((e - m_a[c]) % m_div[c] == 0))) begin
          if (m_prs[c] || (m_pen[c] && !m_en[c])) begin
            m_rst[c] = 1; m_ticks[c] = 0;
          end
          m_en[c] = m_pen[c]; m_div[c] = m_pdiv[c]; m_a[c] = e; m_pv[c] = 0;
        end
      end
    end
    if (!r && we && ch < NUM_CH) begin
      m_pv[ch] = 1; m_pdiv[ch] = (div < 2) ? 2 : div; m_pen[ch] = en; m_prs[ch] = rs;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      exp_clk[c] = clk_at(c, e); exp_tick[c] = tick_at(c, e);
      exp_rst[c] = m_rst[c]; exp_pend[c] = m_pv[c];
    end
  endtask

  task automatic step(input bit we, input int ch, input int div, input bit en, input bit rs, input bit r);
    @(negedge clk);
    rst = r; cfg_we = we; cfg_ch = ch[CH_W-1:0]; cfg_div = div[DIV_W-1:0];
    cfg_en = en; cfg_rst = rs;
    @(posedge clk);
    model_edge(we, ch, div, en, rs, r);
    #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (ch_clk !== ALL0 || ch_tick !== ALL0 || ch_rst !== ALL1 || ch_rst_ !== ALL0 || cfg_pend !== ALL0) begin
      fails++;
      $display("FAIL reset_state clk=%b tick=%b rst=%b rst_=%b pend=%b required 0000 0000 1111 0000 0000",
               ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend);
    end
    for (int n = 0; n < 4; n++) begin
      idle();
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
  endtask

  task automatic test_div4();
    step(1, 0, 4, 1, 0, 0);
    for (int n = 0; n < 26; n++) begin
      idle();
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL div4 cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
    checks++;
    if (ch_rst[0] !== 1'b0) begin
      fails++;
      $display("FAIL div4_rst_release ch_rst0=%b required 0", ch_rst[0]);
    end
  endtask

  task automatic test_odd_and_clamp();
    for (int n = 0; n < 36; n++) begin
      if (n == 0) step(1, 1, 5, 1, 0, 0);
      else if (n == 22) step(1, 1, 0, 1, 0, 0);
      else idle();
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL odd_clamp cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
  endtask

  task automatic test_mid_period_change();
    for (int k = 0; k < 16 && cnt_now(0) != 1; k++) idle();
    step(1, 0, 6, 1, 0, 0);
    checks++;
    if (cfg_pend[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_pend_set pend0=%b required 1", cfg_pend[0]);
    end
    for (int n = 0; n < 24; n++) begin
      idle();
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL mid_change cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
  endtask

  task automatic test_wrap_write();
    step(1, 2, 8, 1, 0, 0);
    for (int k = 0; k < 24 && !(m_en[2] && e > m_a[2] + 8 && cnt_now(2) == 7); k++) idle();
    step(1, 2, 3, 1, 0, 0);
    for (int n = 0; n < 30; n++) begin
      idle();
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL wrap_write cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 3, 6, 1, 0, 0);
    for (int k = 0; k < 24 && !(m_en[3] && e > m_a[3] + 6 && cnt_now(3) == 0); k++) idle();
    for (int n = 0; n < 80; n++) begin
      if (n == 0) step(1, 3, 10, 1, 0, 0);
      else if (n == 1) step(1, 3, 7, 1, 0, 0);
      else if (n == 30) step(1, 3, 7, 1, 1, 0);
      else idle();
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
  endtask

  task automatic test_reset_midop();
    step(1, 0, 3, 1, 0, 0);
    step(1, 1, 4, 1, 0, 0);
    step(1, 2, 5, 1, 0, 0);
    step(1, 3, 7, 1, 0, 0);
    for (int n = 0; n < 9; n++) idle();
    step(1, 1, 9, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (ch_clk !== ALL0 || ch_tick !== ALL0 || ch_rst !== ALL1 || ch_rst_ !== ALL0 || cfg_pend !== ALL0) begin
      fails++;
      $display("FAIL reset_midop clk=%b tick=%b rst=%b rst_=%b pend=%b required 0000 0000 1111 0000 0000",
               ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend);
    end
    for (int n = 0; n < 8; n++) begin
      idle();
      checks++;
      if (ch_clk !== ALL0 || ch_tick !== ALL0 || ch_rst !== ALL1 || cfg_pend !== ALL0) begin
        fails++;
        $display("FAIL post_reset_idle cyc=%0d clk=%b tick=%b rst=%b pend=%b required 0000 0000 1111 0000",
                 e, ch_clk, ch_tick, ch_rst, cfg_pend);
      end
    end
  endtask

  task automatic test_random();
    bit r, we, en, rs;
    int ch, div;
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      we  = !r && ($urandom_range(0, 5) == 0);
      ch  = $urandom_range(0, NUM_CH - 1);
      div = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30) : $urandom_range(0, 11);
      en  = ($urandom_range(0, 7) != 0);
      rs  = ($urandom_range(0, 4) == 0);
      step(we, ch, div, en, rs, r);
      checks++;
      if ({ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend} !== {exp_clk, exp_tick, exp_rst, ~exp_rst, exp_pend}) begin
        fails++;
        $display("FAIL random cyc=%0d got clk=%b tick=%b rst=%b rst_=%b pend=%b exp %b %b %b %b", e,
                 ch_clk, ch_tick, ch_rst, ch_rst_, cfg_pend, exp_clk, exp_tick, exp_rst, exp_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_odd_and_clamp();
    test_mid_period_change();
    test_wrap_write();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/freq_clk_div_multi.md
Name: freq_clk_div_multi

Overview:
Synthesizable multi-channel clock-enable/divided-clock generator with per-channel reset sequencing. It replaces the fixed single-frequency behavioural source for on-chip subsystems that need several programmable rates from one system clock. Each channel has:
- a runtime-programmable integer divisor, odd divisors included;
- glitch-free divisor and enable changes applied at period boundaries;
- a synchronous reset output held for a programmable number of divided periods.

Parameters:
NUM_CH, 4, number of independent divided-clock channels (1..16)
DIV_W, 16, width of divisor field; max divisor 2^DIV_W-1
RST_CYCLES, 4, divided-clock periods each channel reset is held after enable or re-arm (1..255)
DEF_DIV, 2, divisor loaded into every channel at reset (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  config write strobe, single-cycle
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of write
cfg_div  in  DIV_W  requested divisor
cfg_en  in  1  requested channel enable
cfg_rst  in  1  re-arm channel reset sequence on this write
ch_clk  out  NUM_CH  divided clock per channel (registered, data-path use only)
ch_tick  out  NUM_CH  one-cycle pulse in the cycle ch_clk rises
ch_rst  out  NUM_CH  per-channel synchronous reset, active-high
ch_rst_  out  NUM_CH  inverse of ch_rst
cfg_pend  out  NUM_CH  channel holds an accepted write not yet applied

Behaviour:
- Reset (rst=1 at an edge), every channel:
  - cnt=0, div_act=DEF_DIV, en_act=0, pend cleared;
  - ch_clk=0, ch_tick=0, ch_rst=1, ch_rst_=0, cfg_pend=0.
  - Reset mid-operation aborts everything, including pending writes, in that same edge.
- Divisor clamp: a written value D<2 is stored as 2. No other rounding; odd D is legal.
- Per-channel counter:
  - cnt runs 0..div_act-1 while en_act=1, then wraps to 0.
  - The wrap cycle is the cycle with cnt==div_act-1.
- ch_clk:
  - Flop of (en_act && cnt < ceil(div_act/2)), so high phase = ceil(D/2) cycles, low phase = floor(D/2) cycles.
  - Period is exactly D system clocks.
  - One cycle of latency from cnt.
- ch_tick: flop of (en_act && cnt==0). It is coincident with each ch_clk rising cycle.
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - Latches clamp(cfg_div), cfg_en and cfg_rst into the pending registers of cfg_ch and sets cfg_pend.
  - A write with cfg_ch>=NUM_CH is ignored.
  - A second write while pending overwrites the pending values, last write wins.
- Apply rule, from the cycle after the write:
  - Channel idle (en_act=0): pending applies at the next edge. div_act and en_act are loaded, cnt=0, cfg_pend cleared.
  - Channel running: pending applies at the edge ending the wrap cycle. The current period always completes with the old divisor, so there are no runt pulses.
  - A write landing in a wrap cycle applies at the following wrap, not the current one.
- Disable (applied en=0): cnt held at 0, ch_clk=0, ch_tick=0. ch_rst keeps its value.
- Reset sequencer, per channel:
  - rst_cnt is cleared and ch_rst set to 1 on rst, on any applied transition en_act 0->1, and on any applied write with cfg_rst=1.
  - While ch_rst=1, each ch_tick increments rst_cnt.
  - ch_rst is a flop that falls in the cycle after the ch_tick that brings rst_cnt to RST_CYCLES.
  - ch_rst stays high indefinitely while the channel is disabled.
- Channels are fully independent. No cross-channel arbitration; only one config write per cycle.

Test Plan:
- D=4 on ch0, en=1 after reset. ch_clk repeats 1100, ch_tick every 4 clocks. ch_rst falls the cycle after the 4th tick (RST_CYCLES=4).
- D=5 on ch1. ch_clk repeats 11100, period 5, ch_tick every 5 clocks. D=0 write yields period 2 (10).
- ch0 running D=4, write D=6 while cnt=1. cfg_pend=1 until the wrap. The current period completes at 4 clocks, then 6-clock periods (111000). No pulse shorter than 2.
- Write to ch2 in its wrap cycle, D=3 from D=8. The current 8-period and one further 8-period complete, then 110 repeats.
- Two writes to ch3 before its wrap: D=10 then D=7. Only D=7 is applied. A cfg_rst=1 write re-raises ch_rst for RST_CYCLES ticks while ch_clk continues uninterrupted.
- Assert rst mid-period with all channels enabled and one pending. At the next edge all ch_clk=0, ch_tick=0, ch_rst=1, cfg_pend=0. After release all channels are idle with div_act=DEF_DIV.
